// File: rtl/nr_inv_sqrt_iter_pkg.sv
// Shared types and constants for the Newton-Raphson inverse-square-root refinement block.
package nr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_A = 2'd1,
        MUL_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_INT_WIDTH   = 4;
    localparam int DEF_FRACT_WIDTH = 12;
    localparam int DEF_MAX_ITER    = 3;
    localparam int A_MULT          = 3;  // x_half*y*y spans 3 words, 3F fractional bits
    localparam int P_MULT          = 4;  // y*B spans 4 words, 4F fractional bits

    // 1.5 expressed with 3F fractional bits: 3 * 2^(3F-1).
    function automatic logic [127:0] one_point_five(input int f);
        return 128'd3 << (3 * f - 1);
    endfunction

    // Half an output LSB at the 4F-fraction product scale: 2^(3F-1).
    function automatic logic [127:0] round_const(input int f);
        return 128'd1 << (3 * f - 1);
    endfunction

endpackage

// File: rtl/nr_inv_sqrt_iter_if.sv
// Request/response bundle between the seed stage and the Newton-Raphson refinement block.
interface nr_inv_sqrt_iter_if #(
    parameter int INT_WIDTH   = 4,
    parameter int FRACT_WIDTH = 12,
    parameter int MAX_ITER    = 3
);
    localparam int W      = INT_WIDTH + FRACT_WIDTH;
    localparam int ITER_W = $clog2(MAX_ITER + 1);

    logic              start;
    logic [ITER_W-1:0] n_iter;
    logic [W-1:0]      x_half;
    logic [W-1:0]      y0;
    logic              busy;
    logic              done;
    logic [W-1:0]      y;
    logic              ovf;

    modport master (
        output start, n_iter, x_half, y0,
        input  busy, done, y, ovf
    );

    modport slave (
        input  start, n_iter, x_half, y0,
        output busy, done, y, ovf
    );

endinterface

// File: rtl/nr_fix_mul_rnd.sv
// Unsigned y*B multiply with round-half-up, slice back to Qi.f, overflow flag and
// optional saturation (NR_SATURATE_EN clamps to all-ones, otherwise the result wraps).
module nr_fix_mul_rnd
    import nr_pkg::*;
#(
    parameter int INT_WIDTH   = 4,
    parameter int FRACT_WIDTH = 12,
    localparam int W          = INT_WIDTH + FRACT_WIDTH,
    localparam int B_W        = A_MULT * W,
    localparam int P_W        = P_MULT * W,
    localparam int LSB        = 3 * FRACT_WIDTH,
    localparam int Q_W        = P_W - LSB
) (
    input  logic [W-1:0]   a,
    input  logic [B_W-1:0] b,
    output logic [W-1:0]   res,
    output logic           ovf
);

`ifdef NR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [127:0] RND_FULL = round_const(FRACT_WIDTH);
    localparam logic [P_W-1:0] RND    = RND_FULL[P_W-1:0];

    function automatic logic [P_W-1:0] round_half_up(input logic [P_W-1:0] p);
        return p + RND;
    endfunction

    function automatic logic [W-1:0] saturate(input logic [W-1:0] v, input logic o);
        return (o && SAT_EN) ? {W{1'b1}} : v;
    endfunction

    logic [P_W-1:0] prod;
    logic [Q_W-1:0] scaled;

    // The product cannot carry out of P_W bits, so rounding before the shift is exact.
    always_comb begin
        prod   = P_W'(a) * P_W'(b);
        scaled = Q_W'(round_half_up(prod) >> LSB);
        ovf    = |scaled[Q_W-1:W];
        res    = saturate(scaled[W-1:0], ovf);
    end

endmodule

// File: rtl/nr_inv_sqrt_iter.sv
// Multi-iteration Newton-Raphson refinement y <- y*(1.5 - x_half*y*y) on unsigned Qi.f operands.
// Overflow behaviour selected by NR_SATURATE_EN (see nr_fix_mul_rnd).
module nr_inv_sqrt_iter
    import nr_pkg::*;
#(
    parameter int INT_WIDTH   = DEF_INT_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int MAX_ITER    = DEF_MAX_ITER,
    localparam int ITER_W     = $clog2(MAX_ITER + 1),
    localparam int W          = INT_WIDTH + FRACT_WIDTH,
    localparam int A_W        = A_MULT * W
) (
    input  logic               clk,
    input  logic               rst_n,
    nr_inv_sqrt_iter_if.slave  bus
);

    localparam logic [127:0]        ONE_P5_FULL = one_point_five(FRACT_WIDTH);
    localparam logic signed [A_W:0] ONE_P5      = ONE_P5_FULL[A_W:0];

    state_t            state_q, state_d;
    logic [W-1:0]      x_half_q, x_half_d;
    logic [W-1:0]      y_cur_q, y_cur_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [A_W-1:0]    a_q, a_d;
    logic [W-1:0]      y_q, y_d;
    logic              ovf_q, ovf_d;

    logic [ITER_W-1:0]     n_clamped;
    logic signed [A_W:0]   b_s;
    logic                  b_neg;
    logic [W-1:0]          mul_res;
    logic                  mul_ovf;
    logic [W-1:0]          y_step;

    assign n_clamped = (bus.n_iter > ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : bus.n_iter;

    // B is formed one bit wider than A so a negative correction term is visible as a sign.
    assign b_s   = ONE_P5 - $signed({1'b0, a_q});
    assign b_neg = b_s[A_W];

    nr_fix_mul_rnd #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_mul (
        .a   (y_cur_q),
        .b   (b_s[A_W-1:0]),
        .res (mul_res),
        .ovf (mul_ovf)
    );

    assign y_step = b_neg ? '0 : mul_res;

    always_comb begin
        state_d  = state_q;
        x_half_d = x_half_q;
        y_cur_d  = y_cur_q;
        iter_d   = iter_q;
        a_d      = a_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_half_d = bus.x_half;
                    y_cur_d  = bus.y0;
                    iter_d   = n_clamped;
                    ovf_d    = 1'b0;
                    if (n_clamped == '0) begin
                        y_d     = bus.y0;
                        state_d = DONE;
                    end else begin
                        state_d = MUL_A;
                    end
                end
            end
            MUL_A: begin
                a_d     = A_W'(x_half_q) * A_W'(y_cur_q) * A_W'(y_cur_q);
                state_d = MUL_Y;
            end
            MUL_Y: begin
                y_cur_d = y_step;
                if (b_neg || mul_ovf) begin
                    ovf_d = 1'b1;
                end
                iter_d = iter_q - 1'b1;
                if (iter_q == ITER_W'(1)) begin
                    y_d     = y_step;
                    state_d = DONE;
                end else begin
                    state_d = MUL_A;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single state/datapath register stage; reset clears everything so an abort leaves no stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_half_q <= '0;
            y_cur_q  <= '0;
            iter_q   <= '0;
            a_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_half_q <= x_half_d;
            y_cur_q  <= y_cur_d;
            iter_q   <= iter_d;
            a_q      <= a_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == MUL_A) || (state_q == MUL_Y);
    assign bus.done = (state_q == DONE);
    assign bus.y    = y_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nr_inv_sqrt_iter.sv
// Bench for nr_inv_sqrt_iter: directed vectors, reset abort, start hold and randomized operands.
module tb_nr_inv_sqrt_iter;

`ifdef NR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nr_inv_sqrt_iter_if bus ();

    nr_inv_sqrt_iter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: real-valued update carried out exactly in integers scaled by 2^36.
    function automatic void model(input logic [15:0] x, input logic [15:0] y_in, input int n,
                                  output logic [15:0] y_out, output bit ov);
        longint yc, a, b, p, r;
        yc = longint'(y_in);
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = longint'(x) * yc * yc;
            b = (longint'(3) << 35) - a;
            if (b < 0) begin
                yc = 0;
                ov = 1'b1;
            end else begin
                p = yc * b;
                r = (p + (longint'(1) << 35)) >>> 36;
                if (r > 65535) begin
                    ov = 1'b1;
                    yc = SAT ? 65535 : (r % 65536);
                end else begin
                    yc = r;
                end
            end
        end
        y_out = yc[15:0];
    endfunction

    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] yv,
                         input int n, input bit hold,
                         output logic [15:0] y_o, output logic ovf_o);
        logic [15:0] exp_y;
        bit          exp_ov;
        int          cnt;
        model(x, yv, n, exp_y, exp_ov);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.x_half = x;
        bus.y0     = yv;
        bus.n_iter = 2'(n);
        @(posedge clk);
        #1;
        cnt = 1;
        if (!hold) bus.start = 1'b0;
        bus.x_half = 16'($urandom);
        bus.y0     = 16'($urandom);
        bus.n_iter = 2'($urandom);
        while (!bus.done && cnt < 20) begin
            check({tag, " busy"}, 64'(bus.busy), 64'd1);
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, " latency"}, 64'(cnt), 64'(2 * n + 1));
        check({tag, " y"}, 64'(bus.y), 64'(exp_y));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(exp_ov));
        y_o   = bus.y;
        ovf_o = bus.ovf;
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check({tag, " hold done"}, 64'(bus.done), 64'd1);
                check({tag, " hold busy"}, 64'(bus.busy), 64'd0);
                check({tag, " hold y"}, 64'(bus.y), 64'(exp_y));
            end
            bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " done drop"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [15:0] ry;
        logic        rov;
        bus.start  = 1'b0;
        bus.x_half = '0;
        bus.y0     = '0;
        bus.n_iter = '0;

        #12;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst y", 64'(bus.y), 64'd0);
        check("rst ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("c1", 16'h2000, 16'h0800, 1, 1'b0, ry, rov);
        check("c1 const y", 64'(ry), 64'h0800);
        check("c1 const ovf", 64'(rov), 64'd0);

        do_op("c2a", 16'h1000, 16'h0C00, 1, 1'b0, ry, rov);
        check("c2a const y", 64'(ry), 64'h0B40);
        do_op("c2", 16'h1000, 16'h0C00, 2, 1'b0, ry, rov);
        check("c2 const y", 64'(ry), 64'h0B50);
        check("c2 const ovf", 64'(rov), 64'd0);

        do_op("c3", 16'h0001, 16'hF000, 1, 1'b0, ry, rov);
        check("c3 const y", 64'(ry), SAT ? 64'hFFFF : 64'h5AD1);
        check("c3 const ovf", 64'(rov), 64'd1);

        do_op("c4", 16'h1000, 16'h2000, 1, 1'b0, ry, rov);
        check("c4 const y", 64'(ry), 64'h0000);
        check("c4 const ovf", 64'(rov), 64'd1);

        do_op("c5", 16'h1000, 16'h1234, 0, 1'b0, ry, rov);
        check("c5 const y", 64'(ry), 64'h1234);
        do_op("c5max", 16'h0C00, 16'h0E00, 3, 1'b0, ry, rov);

        // Abort case 2 while in MUL_Y; the previous result is nonzero so the clear is observable.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.x_half = 16'h1000;
        bus.y0     = 16'h0C00;
        bus.n_iter = 2'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort done", 64'(bus.done), 64'd0);
        check("abort y", 64'(bus.y), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("c6", 16'h1000, 16'h0C00, 2, 1'b0, ry, rov);
        check("c6 const y", 64'(ry), 64'h0B50);

        do_op("hold", 16'h1000, 16'h0C00, 2, 1'b1, ry, rov);

        for (int i = 0; i < 40; i++) begin
            do_op("rand", 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), ry, rov);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
